// File: rtl/add_accum_16_if.sv
// Operand and result handshake bundle for add_accum_16.
// The slave side is the accumulator; the master side is the upstream/downstream environment.
interface add_accum_16_if #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
);
    logic [WIDTH-1:0]   A_in;
    logic               Valid_in;
    logic               Last_in;
    logic               Clr_in;
    logic               Ready_out;
    logic [WIDTH-1:0]   S_out;
    logic               C_out;
    logic [COUNT_W-1:0] Count_out;
    logic               Valid_out;
    logic               Ready_in;

    modport slave (
        input  A_in, Valid_in, Last_in, Clr_in, Ready_in,
        output Ready_out, S_out, C_out, Count_out, Valid_out
    );

    modport master (
        output A_in, Valid_in, Last_in, Clr_in, Ready_in,
        input  Ready_out, S_out, C_out, Count_out, Valid_out
    );
endinterface

// File: rtl/add_accum_16.sv
// Streaming frame accumulator: sums operands per frame with sticky carry and a
// saturating operand count, then holds the result until the downstream accepts it.
module add_accum_16 #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic          clk_in,
    input  logic          rst_in,
    add_accum_16_if.slave bus
);
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   acc_nxt_s;
    logic               carry_r;
    logic               carry_nxt_s;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] count_nxt_s;
    logic               ready_r;
    logic               valid_r;
    logic [WIDTH:0]     sum_s;
    logic               accept_s;

    // Plain (WIDTH+1)-bit add so any of the team's adder variants drops in unchanged.
    function automatic logic [WIDTH:0] wide_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign sum_s    = wide_add(acc_r, bus.A_in);
    assign accept_s = bus.Valid_in & ready_r;

    // Next-state and datapath update; Clr_in overrides everything, including an accept.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        carry_nxt_s = carry_r;
        count_nxt_s = count_r;
        if (bus.Clr_in) begin
            state_nxt_s = ACCUM;
            acc_nxt_s   = {WIDTH{1'b0}};
            carry_nxt_s = 1'b0;
            count_nxt_s = {COUNT_W{1'b0}};
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        acc_nxt_s   = sum_s[WIDTH-1:0];
                        carry_nxt_s = carry_r | sum_s[WIDTH];
                        count_nxt_s = (count_r == COUNT_MAX) ? count_r : (count_r + COUNT_ONE);
                        state_nxt_s = bus.Last_in ? HOLD : ACCUM;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end
                HOLD: begin
                    if (bus.Ready_in) begin
                        state_nxt_s = ACCUM;
                        acc_nxt_s   = {WIDTH{1'b0}};
                        carry_nxt_s = 1'b0;
                        count_nxt_s = {COUNT_W{1'b0}};
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ACCUM;
                    acc_nxt_s   = {WIDTH{1'b0}};
                    carry_nxt_s = 1'b0;
                    count_nxt_s = {COUNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, datapath and handshake flops; handshake outputs are decoded from the next state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= ACCUM;
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            count_r <= {COUNT_W{1'b0}};
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            carry_r <= carry_nxt_s;
            count_r <= count_nxt_s;
            ready_r <= (state_nxt_s == ACCUM);
            valid_r <= (state_nxt_s == HOLD);
        end
    end

    assign bus.Ready_out = ready_r;
    assign bus.Valid_out = valid_r;
    assign bus.S_out     = acc_r;
    assign bus.C_out     = carry_r;
    assign bus.Count_out = count_r;
endmodule

// File: tb/tb_add_accum_16.sv
// Randomized and directed bench for add_accum_16 against a frame-level model
// (unbounded running total, operand tally, hold flag).
module tb_add_accum_16;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   check_cnt;

    add_accum_16_if #(.WIDTH(16), .COUNT_W(8)) bus ();

    add_accum_16 #(.WIDTH(16), .COUNT_W(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the true sum overflows 16 bits exactly when some partial add carried.
    longint m_total;
    int     m_n;
    bit     m_hold;

    always @(posedge clk or posedge rst) begin
        if (rst || bus.Clr_in) begin
            m_total = 0; m_n = 0; m_hold = 1'b0;
        end else if (!m_hold) begin
            if (bus.Valid_in) begin
                m_total = m_total + longint'(bus.A_in);
                m_n     = m_n + 1;
                if (bus.Last_in) m_hold = 1'b1;
            end
        end else if (bus.Ready_in) begin
            m_total = 0; m_n = 0; m_hold = 1'b0;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready", longint'(bus.Ready_out), longint'(!m_hold));
            check("valid", longint'(bus.Valid_out), longint'(m_hold));
            check("sum",   longint'(bus.S_out),     m_total % 65536);
            check("carry", longint'(bus.C_out),     longint'(m_total >= 65536));
            check("count", longint'(bus.Count_out), longint'((m_n > 255) ? 255 : m_n));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand until accepted; bounded wait.
    task automatic send(input logic [15:0] a, input logic last);
        bit done;
        done = 1'b0;
        bus.Valid_in = 1'b1;
        bus.A_in     = a;
        bus.Last_in  = last;
        for (int k = 0; k < 20 && !done; k++) begin
            if (bus.Ready_out) done = 1'b1;
            tick();
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
        bus.Valid_in = 1'b0;
        bus.Last_in  = 1'b0;
    endtask

    task automatic consume();
        bus.Ready_in = 1'b1;
        tick();
        bus.Ready_in = 1'b0;
    endtask

    initial begin
        pass_cnt = 0; check_cnt = 0;
        rst = 1'b1;
        bus.A_in = 16'd0; bus.Valid_in = 1'b0; bus.Last_in = 1'b0;
        bus.Clr_in = 1'b0; bus.Ready_in = 1'b0;
        #12;
        check("rst_ready", longint'(bus.Ready_out), 64'd1);
        check("rst_valid", longint'(bus.Valid_out), 64'd0);
        check("rst_sum",   longint'(bus.S_out),     64'd0);
        check("rst_count", longint'(bus.Count_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Overflow into a zero sum
        send(16'hFFFF, 1'b0);
        send(16'd1, 1'b1);
        check("t1_valid", longint'(bus.Valid_out), 64'd1);
        check("t1_sum",   longint'(bus.S_out),     64'd0);
        check("t1_carry", longint'(bus.C_out),     64'd1);
        check("t1_count", longint'(bus.Count_out), 64'd2);
        consume();
        check("t1_ready_after", longint'(bus.Ready_out), 64'd1);

        // Ready_in held high, then back-to-back single-operand frame
        bus.Ready_in = 1'b1;
        send(16'd1024, 1'b0);
        send(16'd1023, 1'b1);
        check("t2_sum",   longint'(bus.S_out),     64'd2047);
        check("t2_carry", longint'(bus.C_out),     64'd0);
        check("t2_count", longint'(bus.Count_out), 64'd2);
        tick();
        check("t2_ready_after", longint'(bus.Ready_out), 64'd1);
        send(16'd5, 1'b1);
        check("t2b_sum",   longint'(bus.S_out),     64'd5);
        check("t2b_count", longint'(bus.Count_out), 64'd1);
        tick();
        bus.Ready_in = 1'b0;

        // Backpressure with Valid_in asserted
        send(16'd10, 1'b0);
        send(16'd20, 1'b1);
        bus.Valid_in = 1'b1; bus.A_in = 16'd99;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", longint'(bus.Ready_out), 64'd0);
            check("bp_sum",   longint'(bus.S_out),     64'd30);
            check("bp_count", longint'(bus.Count_out), 64'd2);
            tick();
        end
        bus.Ready_in = 1'b1;
        tick();
        bus.Ready_in = 1'b0; bus.Valid_in = 1'b0;
        check("bp_ready_after", longint'(bus.Ready_out), 64'd1);
        check("bp_valid_after", longint'(bus.Valid_out), 64'd0);
        check("bp_count_after", longint'(bus.Count_out), 64'd0);

        // Clear mid-frame discards the concurrent operand
        send(16'd100, 1'b0);
        send(16'd200, 1'b0);
        bus.Valid_in = 1'b1; bus.A_in = 16'd7; bus.Clr_in = 1'b1;
        tick();
        bus.Valid_in = 1'b0; bus.Clr_in = 1'b0;
        check("clr_sum",   longint'(bus.S_out),     64'd0);
        check("clr_count", longint'(bus.Count_out), 64'd0);
        check("clr_ready", longint'(bus.Ready_out), 64'd1);
        send(16'd3, 1'b1);
        check("clr2_sum",   longint'(bus.S_out),     64'd3);
        check("clr2_count", longint'(bus.Count_out), 64'd1);
        consume();

        // Count saturation
        for (int i = 0; i < 300; i++) send(16'd1, (i == 299));
        check("sat_sum",   longint'(bus.S_out),     64'd300);
        check("sat_carry", longint'(bus.C_out),     64'd0);
        check("sat_count", longint'(bus.Count_out), 64'd255);
        consume();

        // Asynchronous reset between edges
        send(16'd9, 1'b0);
        send(16'd9, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sum",   longint'(bus.S_out),     64'd0);
        check("arst_carry", longint'(bus.C_out),     64'd0);
        check("arst_count", longint'(bus.Count_out), 64'd0);
        check("arst_valid", longint'(bus.Valid_out), 64'd0);
        check("arst_ready", longint'(bus.Ready_out), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Random traffic; the per-cycle compare checks every output
        for (int c = 0; c < 3000; c++) begin
            bus.Valid_in = ($urandom_range(3) != 0);
            bus.A_in     = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
            bus.Last_in  = ($urandom_range(4) == 0);
            bus.Ready_in = ($urandom_range(2) != 0);
            bus.Clr_in   = ($urandom_range(49) == 0);
            tick();
        end
        bus.Valid_in = 1'b0; bus.Clr_in = 1'b0; bus.Ready_in = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
